// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default floor count, SCAN direction and
// engine encodings, and a one-hot to index helper.
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 3;

  // SCAN travel direction; the encoding doubles as the direction output bit.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Motor commands issued by the movement block.
  typedef enum logic [1:0] {
    ENG_STOP = 2'd0,
    ENG_UP   = 2'd1,
    ENG_DOWN = 2'd2
  } engine_e;

  // Index of the set bit of a one-hot vector (zero-extended to 32 bits).
  // The result is meaningless for inputs that are not one-hot.
  function automatic int onehot_to_idx(input logic [31:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-flop synchronizer, stability counter and a one-cycle
// accept pulse per press. A press is accepted on the DEBOUNCE_CYCLES-th
// consecutive high sample; it re-arms only after DEBOUNCE_CYCLES low samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_raw,
  output logic o_accept
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;   // debounced button level
  logic [CW-1:0] r_cnt;     // consecutive samples disagreeing with r_level
  logic          w_last_sample;

  // The current sample is the one that completes the stable run.
  assign w_last_sample = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Pulse combinationally so the request is latched on the accepting edge.
  assign o_accept = r_sync1 & ~r_level & w_last_sample;

  // Synchronize the raw input and track how long it has disagreed with the
  // debounced level; any agreeing sample restarts the run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      if (r_sync1 != r_level) begin
        if (w_last_sample) begin
          r_level <= r_sync1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/request_scheduler.sv
// Latches debounced cabin/landing requests, clears them when the doors open
// at the requested floor, and picks the next target with a SCAN policy.
module request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = DEFAULT_NUM_FLOORS,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_FLOORS-1:0] interior_panel,
  input  logic [NUM_FLOORS-1:0] exterior_panel,
  input  logic [NUM_FLOORS-1:0] current_floor,
  input  logic [NUM_FLOORS-1:0] doors,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] target_floor,
  output logic                  target_valid,
  output logic                  direction
);

  logic [NUM_FLOORS-1:0] w_acc_int;
  logic [NUM_FLOORS-1:0] w_acc_ext;
  logic [NUM_FLOORS-1:0] w_set;

  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] r_target;
  logic                  r_valid;
  dir_e                  r_dir;

  logic                  w_at_floor;
  int                    w_cf;
  logic                  w_here;
  logic [NUM_FLOORS-1:0] w_lo_above;
  logic [NUM_FLOORS-1:0] w_hi_below;

  // One debouncer per cabin button and per landing button.
  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_int (
        .CLK      (CLK),
        .RST      (RST),
        .i_raw    (interior_panel[gi]),
        .o_accept (w_acc_int[gi])
      );
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext (
        .CLK      (CLK),
        .RST      (RST),
        .i_raw    (exterior_panel[gi]),
        .o_accept (w_acc_ext[gi])
      );
    end
  endgenerate

  assign w_set = w_acc_int | w_acc_ext;

  // Latch requests; open doors clear a floor and absorb a simultaneous press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_set) & ~doors;
    end
  end

  assign w_at_floor = $onehot(current_floor);
  assign w_cf       = onehot_to_idx(32'(current_floor));
  // A request at this floor that is not already being served.
  assign w_here     = |(r_pending & current_floor & ~doors);

  // Nearest pending floor above and below the current floor, one-hot.
  always_comb begin
    w_lo_above = '0;
    w_hi_below = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (i > w_cf)) begin
        w_lo_above    = '0;
        w_lo_above[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i] && (i < w_cf)) begin
        w_hi_below    = '0;
        w_hi_below[i] = 1'b1;
      end
    end
  end

  // SCAN direction FSM with registered target; everything holds between floors.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_target <= '0;
      r_valid  <= 1'b0;
      r_dir    <= DIR_UP;
    end else if (w_at_floor) begin
      if (r_pending == '0) begin
        r_target <= '0;
        r_valid  <= 1'b0;
      end else if (w_here) begin
        r_target <= current_floor;
        r_valid  <= 1'b1;
      end else begin
        case (r_dir)
          DIR_UP: begin
            if (w_lo_above != '0) begin
              r_target <= w_lo_above;
              r_valid  <= 1'b1;
            end else if (w_hi_below != '0) begin
              r_dir    <= DIR_DOWN;
              r_target <= w_hi_below;
              r_valid  <= 1'b1;
            end else begin
              // Only this floor is pending and it is being served right now.
              r_target <= '0;
              r_valid  <= 1'b0;
            end
          end
          default: begin
            if (w_hi_below != '0) begin
              r_target <= w_hi_below;
              r_valid  <= 1'b1;
            end else if (w_lo_above != '0) begin
              r_dir    <= DIR_UP;
              r_target <= w_lo_above;
              r_valid  <= 1'b1;
            end else begin
              r_target <= '0;
              r_valid  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign pending      = r_pending;
  assign target_floor = r_target;
  assign target_valid = r_valid;
  assign direction    = r_dir;

endmodule

// File: tb/tb_request_scheduler.sv
// Directed bench for request_scheduler: hand-written debounce/reset sequences
// plus a table of {inputs, cycles, expected outputs} steps for SCAN behaviour.
module tb_request_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] interior_panel;
  logic [2:0] exterior_panel;
  logic [2:0] current_floor;
  logic [2:0] doors;
  logic [2:0] pending;
  logic [2:0] target_floor;
  logic       target_valid;
  logic       direction;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] intr;
    logic [2:0] extr;
    logic [2:0] cur;
    logic [2:0] drs;
    int         n;
    logic [2:0] e_pend;
    logic [2:0] e_tgt;
    logic       e_valid;
    logic       e_dir;
  } vec_t;

  vec_t tbl [11];

  request_scheduler #(.NUM_FLOORS(3), .DEBOUNCE_CYCLES(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .interior_panel (interior_panel),
    .exterior_panel (exterior_panel),
    .current_floor  (current_floor),
    .doors          (doors),
    .pending        (pending),
    .target_floor   (target_floor),
    .target_valid   (target_valid),
    .direction      (direction)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] p, input logic [2:0] t,
                           input logic v, input logic d);
    check({tag, " pending"}, 32'(pending), 32'(p));
    check({tag, " target"}, 32'(target_floor), 32'(t));
    check({tag, " valid"}, 32'(target_valid), 32'(v));
    check({tag, " dir"}, 32'(direction), 32'(d));
    $display("step %s: pending=%b target=%b valid=%b dir=%b", tag, pending, target_floor,
             target_valid, direction);
  endtask

  initial begin
    // Reset with every button pressed.
    RST = 1'b1;
    interior_panel = 3'b111;
    exterior_panel = 3'b111;
    current_floor  = 3'b001;
    doors          = 3'b000;
    tick();
    tick();
    check_all("reset", 3'b000, 3'b000, 1'b0, 1'b1);
    interior_panel = 3'b000;
    exterior_panel = 3'b000;
    tick();
    RST = 1'b0;

    // Single press: pending at edge 6, target at edge 7.
    interior_panel = 3'b010;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 5) check("press edge5 pending", 32'(pending), 32'h0);
      if (e == 6) begin
        check("press edge6 pending", 32'(pending), 32'h2);
        check("press edge6 valid", 32'(target_valid), 32'h0);
      end
      if (e == 7) check_all("press edge7", 3'b010, 3'b010, 1'b1, 1'b1);
    end

    // Release briefly while serving floor 1, then re-press: must not re-trigger.
    interior_panel = 3'b000;
    doors = 3'b010;
    tick();
    check("door clear pending", 32'(pending), 32'h0);
    doors = 3'b000;
    tick();
    interior_panel = 3'b010;
    for (int e = 1; e <= 10; e++) tick();
    check("short release no retrigger", 32'(pending), 32'h0);

    // Full release (4+ low samples) re-arms the button.
    interior_panel = 3'b000;
    for (int e = 1; e <= 8; e++) tick();
    interior_panel = 3'b010;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check("rearm edge5 pending", 32'(pending), 32'h0);
      if (e == 6) check("rearm edge6 pending", 32'(pending), 32'h2);
    end

    // Glitch of 3 samples is rejected.
    interior_panel = 3'b000;
    doors = 3'b010;
    tick();
    doors = 3'b000;
    exterior_panel = 3'b100;
    for (int e = 1; e <= 3; e++) tick();
    exterior_panel = 3'b000;
    for (int e = 1; e <= 8; e++) tick();
    check("glitch pending", 32'(pending), 32'h0);

    // Clean start for the SCAN table.
    RST = 1'b1;
    current_floor = 3'b010;
    tick();
    tick();
    RST = 1'b0;

    tbl[0]  = '{3'b101, 3'b000, 3'b010, 3'b000, 6, 3'b101, 3'b000, 1'b0, 1'b1};
    tbl[1]  = '{3'b000, 3'b000, 3'b010, 3'b000, 1, 3'b101, 3'b100, 1'b1, 1'b1};
    tbl[2]  = '{3'b000, 3'b000, 3'b000, 3'b000, 2, 3'b101, 3'b100, 1'b1, 1'b1};
    tbl[3]  = '{3'b000, 3'b000, 3'b100, 3'b100, 1, 3'b001, 3'b001, 1'b1, 1'b0};
    tbl[4]  = '{3'b000, 3'b000, 3'b100, 3'b000, 1, 3'b001, 3'b001, 1'b1, 1'b0};
    tbl[5]  = '{3'b010, 3'b000, 3'b010, 3'b010, 8, 3'b001, 3'b001, 1'b1, 1'b0};
    tbl[6]  = '{3'b000, 3'b000, 3'b010, 3'b000, 6, 3'b001, 3'b001, 1'b1, 1'b0};
    tbl[7]  = '{3'b000, 3'b100, 3'b000, 3'b000, 7, 3'b101, 3'b001, 1'b1, 1'b0};
    tbl[8]  = '{3'b000, 3'b000, 3'b001, 3'b001, 1, 3'b100, 3'b100, 1'b1, 1'b1};
    tbl[9]  = '{3'b000, 3'b000, 3'b100, 3'b100, 2, 3'b000, 3'b000, 1'b0, 1'b1};
    tbl[10] = '{3'b010, 3'b000, 3'b010, 3'b000, 7, 3'b010, 3'b010, 1'b1, 1'b1};

    for (int k = 0; k < 11; k++) begin
      interior_panel = tbl[k].intr;
      exterior_panel = tbl[k].extr;
      current_floor  = tbl[k].cur;
      doors          = tbl[k].drs;
      for (int c = 0; c < tbl[k].n; c++) tick();
      check_all($sformatf("vec%0d", k), tbl[k].e_pend, tbl[k].e_tgt, tbl[k].e_valid,
                tbl[k].e_dir);
    end

    // Reset with a request pending clears everything.
    RST = 1'b1;
    interior_panel = 3'b000;
    doors = 3'b000;
    tick();
    check_all("reset pending", 3'b000, 3'b000, 1'b0, 1'b1);
    RST = 1'b0;

    // Reset mid-debounce restarts the count from scratch.
    current_floor = 3'b010;
    interior_panel = 3'b001;
    for (int e = 1; e <= 4; e++) tick();
    RST = 1'b1;
    tick();
    check("mid-debounce reset pending", 32'(pending), 32'h0);
    RST = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check("post-reset edge5 pending", 32'(pending), 32'h0);
      if (e == 6) check("post-reset edge6 pending", 32'(pending), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
